// File: rtl/mult_hilo_ctrl.sv
// Sequencer for unsigned multiply (multu) with the HI/LO pair read by mfhi/mflo.
// Latency: start at edge 0 commits HI/LO at edge WIDTH, and done pulses in the following cycle.
// Backpressure: stall holds start and rd_hi/rd_lo while a multiply runs; they are accepted in the done cycle.
module mult_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] result,
    output logic             stall,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      cnt;

    // The final step's addend is folded in so the commit edge needs no extra cycle.
    assign acc_nxt = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, opa};
                        mplier <= opb;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        {hi, lo} <= acc_nxt;
                        state    <= IDLE;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == RUN);
    assign stall = busy & (start | rd_hi | rd_lo);

    always_comb begin
        result = '0;
        if (!stall) begin
            if (rd_hi)
                result = hi;
            else if (rd_lo)
                result = lo;
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl: latency, HI/LO values, stall and reset behaviour.
module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        rd_hi;
    logic        rd_lo;
    logic [31:0] result;
    logic        stall;
    logic        busy;
    logic        done;

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;

    mult_hilo_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opa    (opa),
        .opb    (opb),
        .rd_hi  (rd_hi),
        .rd_lo  (rd_lo),
        .result (result),
        .stall  (stall),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic h, input logic l, output logic [31:0] r, output logic s);
        rd_hi = h;
        rd_lo = l;
        #1;
        r = result;
        s = stall;
        rd_hi = 1'b0;
        rd_lo = 1'b0;
    endtask

    // Issues a multiply, scrambles the operand inputs during RUN, and returns busy cycle count.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, output int lat);
        start = 1'b1;
        opa   = a;
        opb   = b;
        tick();
        start = 1'b0;
        opa   = 32'hDEAD_BEEF;
        opb   = 32'h1357_9BDF;
        lat   = 0;
        while (busy && lat < 100) begin
            lat++;
            tick();
        end
    endtask

    logic [31:0] r;
    logic        s;
    int          lat;
    int          n;
    int          dc0;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        opa   = '0;
        opb   = '0;
        rd_hi = 1'b1;
        rd_lo = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_result", result, 0);
        rd_hi = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 3 x 5
        dc0 = done_cnt;
        do_mult(32'd3, 32'd5, lat);
        chk("t1_latency", lat, 32);
        chk("t1_done", done, 1);
        tick();
        chk("t1_done_clr", done, 0);
        chk("t1_done_once", done_cnt - dc0, 1);
        rd(1'b1, 1'b0, r, s);
        chk("t1_hi", r, 32'h0000_0000);
        rd(1'b0, 1'b1, r, s);
        chk("t1_lo", r, 32'h0000_000F);
        chk("t1_rd_stall", s, 0);

        // max x max
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("t2_latency", lat, 32);
        rd(1'b1, 1'b0, r, s);
        chk("t2_hi", r, 32'hFFFF_FFFE);
        rd(1'b0, 1'b1, r, s);
        chk("t2_lo", r, 32'h0000_0001);

        // zero multiplier, no early exit
        do_mult(32'h1234_5678, 32'h0, lat);
        chk("t2z_latency", lat, 32);
        rd(1'b1, 1'b0, r, s);
        chk("t2z_hi", r, 0);
        rd(1'b0, 1'b1, r, s);
        chk("t2z_lo", r, 0);

        // mflo held from the second RUN cycle
        tick();
        start = 1'b1;
        opa   = 32'h0001_0000;
        opb   = 32'h0001_0000;
        tick();
        start = 1'b0;
        tick();
        rd_lo = 1'b1;
        #1;
        n = 0;
        while (stall && n < 100) begin
            if (result !== 32'h0) chk("t3_stalled_result", result, 0);
            n++;
            tick();
        end
        chk("t3_stall_cycles", n, 31);
        chk("t3_done", done, 1);
        chk("t3_stall_done", stall, 0);
        chk("t3_lo_done_cycle", result, 32'h0000_0000);
        rd_lo = 1'b0;
        rd(1'b1, 1'b0, r, s);
        chk("t3_hi", r, 32'h0000_0001);
        tick();

        // back-to-back: 7x6 then 2x2 held from 2 cycles after first start
        dc0   = done_cnt;
        start = 1'b1;
        opa   = 32'd7;
        opb   = 32'd6;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        opa   = 32'd2;
        opb   = 32'd2;
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            tick();
        end
        chk("t4_stall_cycles", n, 31);
        chk("t4_done1", done, 1);
        rd(1'b0, 1'b1, r, s);
        chk("t4_lo1", r, 32'd42);
        chk("t4_rd_stall", s, 0);
        rd(1'b1, 1'b0, r, s);
        chk("t4_hi1", r, 32'd0);
        tick();
        start = 1'b0;
        chk("t4_accepted", busy, 1);
        lat = 0;
        while (busy && lat < 100) begin
            lat++;
            tick();
        end
        chk("t4_latency2", lat, 32);
        rd(1'b0, 1'b1, r, s);
        chk("t4_lo2", r, 32'd4);
        rd(1'b1, 1'b0, r, s);
        chk("t4_hi2", r, 32'd0);
        tick();
        chk("t4_done_twice", done_cnt - dc0, 2);

        // reset during RUN cycle 10
        dc0   = done_cnt;
        start = 1'b1;
        opa   = 32'hFFFF_FFFF;
        opb   = 32'd2;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("t5_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_done_rst", done, 0);
        rd(1'b1, 1'b0, r, s);
        chk("t5_hi_rst", r, 0);
        rd(1'b0, 1'b1, r, s);
        chk("t5_lo_rst", r, 0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        chk("t5_no_done", done_cnt - dc0, 0);
        chk("t5_idle", busy, 0);
        rd(1'b0, 1'b1, r, s);
        chk("t5_lo_still0", r, 0);
        do_mult(32'd4, 32'd4, lat);
        chk("t5_latency", lat, 32);
        rd(1'b0, 1'b1, r, s);
        chk("t5_lo16", r, 32'd16);

        // HI wins when both reads asserted, including alongside a start
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        tick();
        rd(1'b1, 1'b1, r, s);
        chk("t6_both_result", r, 32'hFFFF_FFFE);
        chk("t6_both_stall", s, 0);
        start = 1'b1;
        opa   = 32'd5;
        opb   = 32'd5;
        rd_hi = 1'b1;
        rd_lo = 1'b1;
        #1;
        chk("t6_start_result", result, 32'hFFFF_FFFE);
        chk("t6_start_stall", stall, 0);
        tick();
        start = 1'b0;
        rd_hi = 1'b0;
        rd_lo = 1'b0;
        chk("t6_busy", busy, 1);
        lat = 0;
        while (busy && lat < 100) begin
            lat++;
            tick();
        end
        chk("t6_latency", lat, 32);
        rd(1'b0, 1'b1, r, s);
        chk("t6_lo25", r, 32'd25);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
